cache_bank_scheduler: RTL

//  Round-robin scheduler sharing BANKS single-ported cache banks among NREQ requesters.

---
 rtl/cache_bank_scheduler_pkg.sv | 32 +++
 rtl/cache_bank_scheduler_rr_picker.sv | 38 +++
 rtl/cache_bank_scheduler.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/cache_bank_scheduler_pkg.sv
// Shared types and helpers for the banked cache scheduler.
// The typedefs describe the default configuration (4 requesters, 4 banks,
// 12-bit address, 32-bit data) for neighbouring blocks. The scheduler builds
// its own types from its parameters, so overriding them stays consistent.
package cache_sched_pkg;

  localparam int NREQ_DEF   = 4;
  localparam int BANKS_DEF  = 4;
  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;

  // Index width that never collapses to zero bits (n==1 still needs a 1-bit field)
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef logic [idx_w(BANKS_DEF)-1:0] BankIdx;
  typedef logic [idx_w(NREQ_DEF)-1:0]  ReqIdx;

  typedef struct packed {
    logic                      we;
    logic [ADDR_W_DEF-1:0]     addr;
    logic [DATA_W_DEF-1:0]     wdata;
    logic [DATA_W_DEF/8-1:0]   wmask;
  } BankReq;

  typedef struct packed {
    logic  valid;
    ReqIdx idx;
  } RdTrack;

endpackage

// File: rtl/cache_bank_scheduler_rr_picker.sv
// rr_picker: round-robin pick of one requester starting at ptr, wrapping
// modulo NREQ. Purely combinational; the caller owns the pointer register.
module rr_picker
  import cache_sched_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int RIW  = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [RIW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [RIW-1:0]  idx,
  output logic            any
);

  logic [RIW:0]   sum;
  logic [RIW-1:0] j;

  // Scan offsets 0..NREQ-1 from ptr; first asserted request wins
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    sum = '0;
    j   = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + (RIW+1)'(i);
      if (sum >= (RIW+1)'(NREQ)) sum = sum - (RIW+1)'(NREQ);
      j = sum[RIW-1:0];
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/cache_bank_scheduler.sv
// cache_bank_scheduler: shares BANKS single-ported SRAM banks among NREQ
// requesters with a per-bank round-robin arbiter. Grants are combinational,
// the bank port is registered, read data returns 1+RD_LAT cycles after grant.
// Optional: define CACHE_BANK_SCHED_PERF_EN to add per-bank conflict counters
// (OUT_perfConflicts).
// RD_LAT must be >= 1.
module cache_bank_scheduler
  import cache_sched_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int BANKS       = 4,
  parameter int BANK_OFFSET = 2,
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int RD_LAT      = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NREQ-1:0]                    IN_valid,
  input  logic [NREQ-1:0]                    IN_we,
  input  logic [NREQ-1:0][ADDR_W-1:0]        IN_addr,
  input  logic [NREQ-1:0][DATA_W-1:0]        IN_wdata,
  input  logic [NREQ-1:0][DATA_W/8-1:0]      IN_wmask,
  output logic [NREQ-1:0]                    OUT_ready,
  output logic [NREQ-1:0]                    OUT_rvalid,
  output logic [NREQ-1:0][DATA_W-1:0]        OUT_rdata,
  output logic [BANKS-1:0]                   OUT_bankCe,
  output logic [BANKS-1:0]                   OUT_bankWe,
  output logic [BANKS-1:0][ADDR_W-1:0]       OUT_bankAddr,
  output logic [BANKS-1:0][DATA_W-1:0]       OUT_bankWData,
  output logic [BANKS-1:0][DATA_W/8-1:0]     OUT_bankWMask,
`ifdef CACHE_BANK_SCHED_PERF_EN
  output logic [BANKS-1:0][31:0]             OUT_perfConflicts,
`endif
  input  logic [BANKS-1:0][DATA_W-1:0]       IN_bankRData
);

  localparam int MW  = DATA_W / 8;
  localparam int RIW = idx_w(NREQ);
  localparam int BIW = idx_w(BANKS);

  logic [NREQ-1:0][BIW-1:0]  req_bank;
  logic [BANKS-1:0][NREQ-1:0] gnt;
  logic [BANKS-1:0]           ret_v;
  logic [BANKS-1:0][RIW-1:0]  ret_idx;

  // Bank select field; a single bank needs no address bits
  if (BANKS == 1) begin : g_one_bank
    assign req_bank = '0;
  end else begin : g_multi_bank
    for (genvar r = 0; r < NREQ; r++) begin : g_sel
      assign req_bank[r] = IN_addr[r][BANK_OFFSET +: BIW];
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [NREQ-1:0]   cand;
    logic [RIW-1:0]    ptr, win;
    logic              any;
    logic              ce_q, we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MW-1:0]     wmask_q;
    // stage 0 is the port-drive cycle, stage RD_LAT is when bank data is valid
    logic [RD_LAT:0]          vld_pipe;
    logic [RD_LAT:0][RIW-1:0] idx_pipe;

    // Candidates: valid requests whose address selects this bank
    always_comb begin
      cand = '0;
      for (int r = 0; r < NREQ; r++)
        cand[r] = IN_valid[r] && (req_bank[r] == BIW'(b));
    end

    rr_picker #(.NREQ(NREQ)) u_pick (
      .req (cand),
      .ptr (ptr),
      .gnt (gnt[b]),
      .idx (win),
      .any (any)
    );

    // Rotate pointer past the winner and register the granted request onto the port
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ptr     <= '0;
        ce_q    <= 1'b1;
        we_q    <= 1'b1;
        addr_q  <= '0;
        wdata_q <= '0;
        wmask_q <= '0;
      end else begin
        ce_q <= !any;
        if (any) begin
          ptr     <= (win == RIW'(NREQ-1)) ? '0 : win + 1'b1;
          we_q    <= !IN_we[win];
          addr_q  <= IN_addr[win];
          wdata_q <= IN_wdata[win];
          wmask_q <= IN_wmask[win];
        end else begin
          we_q <= 1'b1;
        end
      end
    end

    // Track reads in flight so the returning data can be steered to its requester
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_pipe <= '0;
        idx_pipe <= '0;
      end else begin
        vld_pipe[0] <= any && !IN_we[win];
        idx_pipe[0] <= win;
        for (int k = 1; k <= RD_LAT; k++) begin
          vld_pipe[k] <= vld_pipe[k-1];
          idx_pipe[k] <= idx_pipe[k-1];
        end
      end
    end

    assign OUT_bankCe[b]    = ce_q;
    assign OUT_bankWe[b]    = we_q;
    assign OUT_bankAddr[b]  = addr_q;
    assign OUT_bankWData[b] = wdata_q;
    assign OUT_bankWMask[b] = wmask_q;
    assign ret_v[b]         = vld_pipe[RD_LAT];
    assign ret_idx[b]       = idx_pipe[RD_LAT];

`ifdef CACHE_BANK_SCHED_PERF_EN
    logic [31:0] perf_q;

    // Count cycles where this bank had to turn someone away; saturates
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        perf_q <= '0;
      else if ($countones(cand) > 1 && perf_q != 32'hFFFF_FFFF)
        perf_q <= perf_q + 32'd1;
    end

    assign OUT_perfConflicts[b] = perf_q;
`endif
  end

  // Merge per-bank grants and route returning read data to requesters;
  // rdata is zero whenever its strobe is low
  always_comb begin
    OUT_ready  = '0;
    OUT_rvalid = '0;
    OUT_rdata  = '0;
    for (int b = 0; b < BANKS; b++) begin
      OUT_ready = OUT_ready | gnt[b];
      for (int r = 0; r < NREQ; r++) begin
        if (ret_v[b] && ret_idx[b] == RIW'(r)) begin
          OUT_rvalid[r] = 1'b1;
          OUT_rdata[r]  = OUT_rdata[r] | IN_bankRData[b];
        end
      end
    end
  end

endmodule
